avr_bus_master: RTL

- Initiator for the AVR-style external memory bus: multiplexed 8-bit A/D, 8-bit upper address, ALE, active-low _RD and _WR.
- Turns a simple valid/ready request port into correctly sequenced bus cycles.
- Used as the bus driver in FPGA-hosted test harnesses and coprocessor bridges that access DuinoCube through the same pins an AVR host uses.

---
 rtl/avr_bus_master_pkg.sv | 31 +++
 rtl/avr_bus_master_if.sv | 25 ++
 rtl/avr_bus_phase_counter.sv | 29 ++
 rtl/avr_bus_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/avr_bus_master_pkg.sv
// Shared types and constants for the AVR external-bus master: FSM encoding,
// bus widths, default phase lengths and the phase-counter width helper.
package avr_bus_pkg;

  localparam int AD_W   = 8;
  localparam int AH_W   = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam int DEF_ALE_CYCLES     = 1;
  localparam int DEF_STROBE_CYCLES  = 2;
  localparam int DEF_RECOVER_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_HOLD,
    ST_STROBE,
    ST_RECOVER
  } state_e;

  // The counter only ever holds (length - 1), so it needs clog2(max length) bits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/avr_bus_master_if.sv
// Request/response handshake between a client and avr_bus_master.
// modport master: the bus-master side; modport slave: the request source.
interface avr_bus_master_if;
  import avr_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic              req_word;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    input  req_valid, req_wr, req_word, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    output req_valid, req_wr, req_word, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/avr_bus_phase_counter.sv
// Loadable down-counter timing each bus phase; zero marks the last cycle.
module avr_bus_phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             _reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/avr_bus_master.sv
// AVR-style external memory bus initiator (muxed A/D, ALE, _RD/_WR strobes).
// Define AVR_BUS_MASTER_WORD_EN to enable 16-bit accesses as two byte cycles.
module avr_bus_master
  import avr_bus_pkg::*;
#(
  parameter int ALE_CYCLES     = DEF_ALE_CYCLES,
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic                clk,
  input  logic                _reset,
  avr_bus_master_if.master    req,
  output logic                _mpu_rd,
  output logic                _mpu_wr,
  output logic                mpu_ale,
  output logic [AH_W-1:0]     mpu_ah,
  inout  wire  [AD_W-1:0]     mpu_ad
);

  localparam int CNT_W = cnt_width(ALE_CYCLES, STROBE_CYCLES, RECOVER_CYCLES);
  localparam logic [CNT_W-1:0] ALE_LD = CNT_W'(ALE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LD = CNT_W'(RECOVER_CYCLES - 1);

  state_e            state_q, state_d;
  logic              ale_q, ale_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              ad_oe_q, ad_oe_d;
  logic [AD_W-1:0]   ad_out_q, ad_out_d;
  logic [AH_W-1:0]   ah_q, ah_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              start_addr;
  logic [ADDR_W-1:0] start_a;
  logic              more;
  logic [AD_W-1:0]   wr_byte;

`ifdef AVR_BUS_MASTER_WORD_EN
  logic            word_q, word_d;
  logic            half_q, half_d;
  logic [AD_W-1:0] lo_q, lo_d;

  assign more    = word_q && !half_q;
  assign wr_byte = half_q ? wdata_q[15:8] : wdata_q[7:0];
`else
  logic unused_word;

  assign more        = 1'b0;
  assign wr_byte     = wdata_q[7:0];
  assign unused_word = ^{req.req_word, wdata_q[15:8]};
`endif

  avr_bus_phase_counter #(.WIDTH(CNT_W)) u_phase (
    .clk      (clk),
    ._reset   (_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    ale_d       = 1'b0;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    ad_oe_d     = 1'b0;
    ad_out_d    = ad_out_q;
    ah_d        = ah_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    start_addr  = 1'b0;
    start_a     = addr_q;
`ifdef AVR_BUS_MASTER_WORD_EN
    word_d      = word_q;
    half_d      = half_q;
    lo_d        = lo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req.req_valid && ready_q) begin
          ready_d = 1'b0;
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          wr_d    = req.req_wr;
`ifdef AVR_BUS_MASTER_WORD_EN
          word_d  = req.req_word;
          half_d  = 1'b0;
          if (req.req_word) addr_d[0] = 1'b0;
`endif
          start_addr = 1'b1;
          start_a    = addr_d;
        end
      end
      ST_ADDR: begin
        ale_d   = 1'b1;
        ad_oe_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_HOLD;
          ale_d   = 1'b0;
        end
      end
      ST_HOLD: begin
        state_d  = ST_STROBE;
        cnt_load = 1'b1;
        cnt_val  = STB_LD;
        if (wr_q) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wr_byte;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      ST_STROBE: begin
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        ad_oe_d = ad_oe_q;
        if (cnt_zero) begin
          // Strobe rises here; a write keeps driving its byte for one more cycle.
          state_d     = ST_RECOVER;
          rd_n_d      = 1'b1;
          wr_n_d      = 1'b1;
          cnt_load    = 1'b1;
          cnt_val     = REC_LD;
          rsp_valid_d = !more;
          if (!wr_q) begin
`ifdef AVR_BUS_MASTER_WORD_EN
            if (!word_q)      rdata_d = {8'h00, mpu_ad};
            else if (!half_q) lo_d    = mpu_ad;
            else              rdata_d = {mpu_ad, lo_q};
`else
            rdata_d = {8'h00, mpu_ad};
`endif
          end
        end
      end
      ST_RECOVER: begin
        if (cnt_zero) begin
          if (more) begin
`ifdef AVR_BUS_MASTER_WORD_EN
            half_d = 1'b1;
`endif
            start_addr = 1'b1;
            start_a    = {addr_q[15:1], 1'b1};
          end else begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_addr) begin
      state_d  = ST_ADDR;
      ale_d    = 1'b1;
      ah_d     = start_a[15:8];
      ad_oe_d  = 1'b1;
      ad_out_d = start_a[7:0];
      cnt_load = 1'b1;
      cnt_val  = ALE_LD;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= ST_IDLE;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      ah_q        <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
`ifdef AVR_BUS_MASTER_WORD_EN
      word_q      <= 1'b0;
      half_q      <= 1'b0;
      lo_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ale_q       <= ale_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      ah_q        <= ah_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
`ifdef AVR_BUS_MASTER_WORD_EN
      word_q      <= word_d;
      half_q      <= half_d;
      lo_q        <= lo_d;
`endif
    end
  end

  assign _mpu_rd       = rd_n_q;
  assign _mpu_wr       = wr_n_q;
  assign mpu_ale       = ale_q;
  assign mpu_ah        = ah_q;
  assign mpu_ad        = ad_oe_q ? ad_out_q : 8'hzz;
  assign req.req_ready = ready_q;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_rdata = rdata_q;

endmodule
